conv_stream_feeder: RTL and testbench
=====================================

CONV_STREAM_FEEDER -- requirements
Module: conv_stream_feeder

Interface
REQ-001 SHALL have parameter IFM_WIDTH, default 8, ifm sample width in bits.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, weight width in bits.
REQ-003 SHALL have parameter IFM_SIZE, default 64, unpadded square feature-map side.
REQ-004 SHALL have parameter CI, default 3, input channels.
REQ-005 SHALL have parameter CO, default 8, output filters.
REQ-006 SHALL have parameter KERNEL_SIZE, default 3, kernel side.
REQ-007 SHALL have parameter PAD, default 0, zero border width, legal range 0..2.
REQ-008 SHALL have parameter NUM_FRAMES, default 1, frames stored and streamed per run.
REQ-009 SHALL have port clk2 input 1: the only clock, all logic on its rising edge.
REQ-010 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-011 SHALL have port start input 1: begin a run; one-cycle pulse.
REQ-012 SHALL have port load_we input 1: memory write strobe.
REQ-013 SHALL have port load_sel input 1: write target, 0 = ifm memory, 1 = weight memory.
REQ-014 SHALL have port load_addr input AW: write address, AW = clog2 of the larger memory depth.
REQ-015 SHALL have port load_data input max(IFM_WIDTH,WEIGHT_WIDTH): write data, LSBs used.
REQ-016 SHALL have port ifm_read input 1: request the next ifm element.
REQ-017 SHALL have port wgt_read input 1: request the next weight.
REQ-018 SHALL have port ifm output IFM_WIDTH: ifm data, zero when ifm_valid=0.
REQ-019 SHALL have port ifm_valid output 1: ifm carries a served element.
REQ-020 SHALL have port wgt output WEIGHT_WIDTH: weight data, zero when wgt_valid=0.
REQ-021 SHALL have port wgt_valid output 1: wgt carries a served weight.
REQ-022 SHALL have port frame_done output 1: one-cycle pulse, last element of a frame served.
REQ-023 SHALL have port all_done output 1: sticky, all NUM_FRAMES frames served.
REQ-024 SHALL have port ovf_err output 1: sticky, ifm_read arrived after all_done.

Function
REQ-025 SHALL define P = IFM_SIZE+2*PAD, FRAME_LEN = CI*P*P and WGT_LEN = CO*CI*KERNEL_SIZE*KERNEL_SIZE.
REQ-026 SHALL store ifm memory with depth NUM_FRAMES*CI*IFM_SIZE*IFM_SIZE, layout frame, channel, row, column (column fastest).
REQ-027 SHALL store weight memory with depth WGT_LEN, layout filter, channel, ky, kx.
REQ-028 SHALL step ifm order frame, channel, padded row 0..P-1, padded column 0..P-1, one step per accepted ifm_read.
REQ-029 SHALL serve zero for any position with row or column <PAD or >=PAD+IFM_SIZE, else memory[frame, ch, row-PAD, col-PAD].
REQ-030 SHALL present ifm/ifm_valid exactly 1 cycle after the accepting ifm_read edge; same rule for wgt/wgt_valid.
REQ-031 SHALL wrap the weight index to 0 after WGT_LEN-1, continuously, independent of frames.
REQ-032 SHALL pulse frame_done together with ifm_valid of element FRAME_LEN-1 of each frame.
REQ-033 SHALL set all_done with the final frame_done; afterwards ifm_read is not accepted, ifm_valid stays 0, ovf_err sets.
REQ-034 SHALL on start clear ifm counters, frame count, all_done and ovf_err; the weight index is also cleared.
REQ-035 SHALL give start priority over a same-cycle ifm_read/wgt_read: counters reset, that read serves element 0 and index becomes 1.
REQ-036 SHALL accept load_we at any time; a read of the address written in the same cycle returns the old data.
REQ-037 SHALL accept simultaneous ifm_read and wgt_read independently, no stall.

Reset
REQ-038 SHALL reset asynchronously on rst_n=0: all counters 0, ifm=0, wgt=0, ifm_valid=0, wgt_valid=0, frame_done=0, all_done=0, ovf_err=0.
REQ-039 SHALL leave memory contents unchanged by reset; reset mid-run abandons the run, next element after release is element 0.

Structure
REQ-040 SHALL place P, FRAME_LEN, WGT_LEN, memory depths, AW and a clog2 function in package conv_feeder_pkg.
REQ-041 SHALL implement padded row/column/channel/frame counting and border detection in sub-module pad_addr_gen.

Verification (IFM_SIZE=4, CI=2, CO=2, K=3, PAD=1, NUM_FRAMES=2; P=6, FRAME_LEN=72, WGT_LEN=36)
REQ-042 SHALL check: ifm mem[i]=i+1, start, 72 reads -> elements 0..6 zero, element 7 = 1, element 10 = 4, element 11 = 0, frame_done on element 71.
REQ-043 SHALL check: 144 reads -> second frame element 7 = mem[32]=33, all_done with element 143; 145th read -> ifm_valid=0, ovf_err=1.
REQ-044 SHALL check: weight mem[j]=j+1, 40 wgt_read -> 1..36 then 1..4, each valid 1 cycle after its read.
REQ-045 SHALL check: start and ifm_read in same cycle mid-frame at element 20 -> element 0 (zero) served, next read gives element 1.
REQ-046 SHALL check: rst_n low at element 30 -> all outputs 0 asynchronously; after release, start, 8 reads -> element 7 = 1.

Source files
------------

// File: rtl/conv_feeder_pkg.sv
// Shared geometry helpers for the convolution stream feeder.
// Functions derive the padded side, frame/weight lengths, memory depths and address width.
// Pure constants; no timing or flow-control content.
package conv_feeder_pkg;

    // Ceiling log2, never below 1 so that derived vectors stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // P: padded feature-map side.
    function automatic int padded_side(input int ifm_size, input int pad);
        return ifm_size + 2 * pad;
    endfunction

    // FRAME_LEN: elements streamed per frame, border included.
    function automatic int frame_len(input int ci, input int ifm_size, input int pad);
        return ci * padded_side(ifm_size, pad) * padded_side(ifm_size, pad);
    endfunction

    // WGT_LEN: weight memory depth and wrap length of the weight index.
    function automatic int wgt_len(input int co, input int ci, input int k);
        return co * ci * k * k;
    endfunction

    // ifm memory depth: unpadded samples of every stored frame.
    function automatic int ifm_depth(input int num_frames, input int ci, input int ifm_size);
        return num_frames * ci * ifm_size * ifm_size;
    endfunction

    // AW: load address width covering the larger of the two memories.
    function automatic int load_aw(input int num_frames, input int ci, input int ifm_size,
                                   input int co, input int k);
        return clog2(max2(ifm_depth(num_frames, ci, ifm_size), wgt_len(co, ci, k)));
    endfunction

    // Geometry of the default configuration.
    localparam int DEF_P         = padded_side(64, 0);
    localparam int DEF_FRAME_LEN = frame_len(3, 64, 0);
    localparam int DEF_WGT_LEN   = wgt_len(8, 3, 3);
    localparam int DEF_IFM_DEPTH = ifm_depth(1, 3, 64);
    localparam int DEF_AW        = load_aw(1, 3, 64, 8, 3);

endpackage

// File: rtl/conv_stream_feeder_pad_addr_gen.sv
// Walks frame/channel/padded row/padded column and flags border positions.
// Position outputs are combinational for the current step; counters update on the stepping edge.
// Advances only on step; clear forces the position to element 0 in the same cycle.
module pad_addr_gen
    import conv_feeder_pkg::*;
#(
    parameter int IFM_SIZE   = 64,
    parameter int PAD        = 0,
    parameter int CI         = 3,
    parameter int NUM_FRAMES = 1,
    parameter int ADDR_W     = 8
) (
    input  logic              clk2,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    output logic              pad,
    output logic [ADDR_W-1:0] addr,
    output logic              last_elem,
    output logic              last_frame
);

    localparam int P   = padded_side(IFM_SIZE, PAD);
    localparam int RW  = clog2(P);
    localparam int CHW = clog2(CI);
    localparam int FW  = clog2(NUM_FRAMES);

    logic [RW-1:0]     row_q, col_q, eff_row, eff_col, n_row, n_col;
    logic [CHW-1:0]    ch_q, eff_ch, n_ch;
    logic [FW-1:0]     frame_q, eff_frame, n_frame;
    logic [ADDR_W-1:0] addr_q, eff_addr, n_addr;
    logic              row_in, col_in, col_last, row_last, ch_last;

    // Current position, forced to element 0 while clear is high so a same-cycle read serves it.
    always_comb begin
        eff_row   = clear ? '0 : row_q;
        eff_col   = clear ? '0 : col_q;
        eff_ch    = clear ? '0 : ch_q;
        eff_frame = clear ? '0 : frame_q;
        eff_addr  = clear ? '0 : addr_q;
        row_in    = (int'(eff_row) >= PAD) && (int'(eff_row) < PAD + IFM_SIZE);
        col_in    = (int'(eff_col) >= PAD) && (int'(eff_col) < PAD + IFM_SIZE);
        col_last  = (int'(eff_col) == P - 1);
        row_last  = (int'(eff_row) == P - 1);
        ch_last   = (int'(eff_ch) == CI - 1);
        pad        = !(row_in && col_in);
        addr       = eff_addr;
        last_elem  = col_last && row_last && ch_last;
        last_frame = (int'(eff_frame) == NUM_FRAMES - 1);
    end

    // Next position; the memory address only moves on interior samples, which arrive in memory order.
    always_comb begin
        n_row   = eff_row;
        n_col   = eff_col;
        n_ch    = eff_ch;
        n_frame = eff_frame;
        n_addr  = eff_addr;
        if (step) begin
            if (!pad) n_addr = eff_addr + 1'b1;
            if (col_last) begin
                n_col = '0;
                if (row_last) begin
                    n_row = '0;
                    if (ch_last) begin
                        n_ch = '0;
                        if (last_frame) begin
                            n_frame = '0;
                            n_addr  = '0;
                        end else begin
                            n_frame = eff_frame + 1'b1;
                        end
                    end else begin
                        n_ch = eff_ch + 1'b1;
                    end
                end else begin
                    n_row = eff_row + 1'b1;
                end
            end else begin
                n_col = eff_col + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            col_q   <= '0;
            ch_q    <= '0;
            frame_q <= '0;
            addr_q  <= '0;
        end else begin
            row_q   <= n_row;
            col_q   <= n_col;
            ch_q    <= n_ch;
            frame_q <= n_frame;
            addr_q  <= n_addr;
        end
    end

endmodule

// File: rtl/conv_stream_feeder.sv
// Stores ifm frames and weights, streams padded ifm elements and cyclic weights on request.
// Data and valid appear 1 cycle after the accepting read edge.
// Never stalls; ifm reads after the final frame are dropped and flagged in ovf_err.
module conv_stream_feeder
    import conv_feeder_pkg::*;
#(
    parameter int IFM_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int IFM_SIZE     = 64,
    parameter int CI           = 3,
    parameter int CO           = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int PAD          = 0,
    parameter int NUM_FRAMES   = 1,
    localparam int AW = load_aw(NUM_FRAMES, CI, IFM_SIZE, CO, KERNEL_SIZE),
    localparam int DW = max2(IFM_WIDTH, WEIGHT_WIDTH)
) (
    input  logic                    clk2,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    load_we,
    input  logic                    load_sel,
    input  logic [AW-1:0]           load_addr,
    input  logic [DW-1:0]           load_data,
    input  logic                    ifm_read,
    input  logic                    wgt_read,
    output logic [IFM_WIDTH-1:0]    ifm,
    output logic                    ifm_valid,
    output logic [WEIGHT_WIDTH-1:0] wgt,
    output logic                    wgt_valid,
    output logic                    frame_done,
    output logic                    all_done,
    output logic                    ovf_err
);

    localparam int IFM_DEPTH = ifm_depth(NUM_FRAMES, CI, IFM_SIZE);
    localparam int WGT_DEPTH = wgt_len(CO, CI, KERNEL_SIZE);
    localparam int IAW       = clog2(IFM_DEPTH);
    localparam int WAW       = clog2(WGT_DEPTH);

    logic [IFM_WIDTH-1:0]    ifm_mem [IFM_DEPTH];
    logic [WEIGHT_WIDTH-1:0] wgt_mem [WGT_DEPTH];

    logic           ifm_acc;
    logic           gen_pad, gen_last_elem, gen_last_frame;
    logic [IAW-1:0] gen_addr;
    logic [WAW-1:0] wgt_idx, eff_widx;

    // A start in the same cycle re-opens a finished run, so its read is accepted.
    assign ifm_acc  = ifm_read && (start || !all_done);
    assign eff_widx = start ? '0 : wgt_idx;

    pad_addr_gen #(
        .IFM_SIZE   (IFM_SIZE),
        .PAD        (PAD),
        .CI         (CI),
        .NUM_FRAMES (NUM_FRAMES),
        .ADDR_W     (IAW)
    ) u_gen (
        .clk2       (clk2),
        .rst_n      (rst_n),
        .clear      (start),
        .step       (ifm_acc),
        .pad        (gen_pad),
        .addr       (gen_addr),
        .last_elem  (gen_last_elem),
        .last_frame (gen_last_frame)
    );

    // Memory write ports; contents deliberately survive reset. Out-of-range addresses are ignored.
    always_ff @(posedge clk2) begin
        if (load_we && !load_sel && (32'(load_addr) < IFM_DEPTH))
            ifm_mem[load_addr[IAW-1:0]] <= load_data[IFM_WIDTH-1:0];
        if (load_we && load_sel && (32'(load_addr) < WGT_DEPTH))
            wgt_mem[load_addr[WAW-1:0]] <= load_data[WEIGHT_WIDTH-1:0];
    end

    // ifm serving path plus frame/run status; a same-cycle write is not visible to this read.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            ifm        <= '0;
            ifm_valid  <= 1'b0;
            frame_done <= 1'b0;
            all_done   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            ifm_valid  <= ifm_acc;
            ifm        <= (ifm_acc && !gen_pad) ? ifm_mem[gen_addr] : '0;
            frame_done <= ifm_acc && gen_last_elem;
            if (start) begin
                all_done <= 1'b0;
                ovf_err  <= 1'b0;
            end
            if (ifm_acc && gen_last_elem && gen_last_frame)
                all_done <= 1'b1;
            if (ifm_read && all_done && !start)
                ovf_err <= 1'b1;
        end
    end

    // Weight path: free-running index wrapping at the weight count, restarted by start.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            wgt       <= '0;
            wgt_valid <= 1'b0;
            wgt_idx   <= '0;
        end else begin
            wgt_valid <= wgt_read;
            wgt       <= wgt_read ? wgt_mem[eff_widx] : '0;
            if (wgt_read)
                wgt_idx <= (int'(eff_widx) == WGT_DEPTH - 1) ? '0 : eff_widx + 1'b1;
            else
                wgt_idx <= eff_widx;
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder: IFM_SIZE=4, CI=2, CO=2, K=3, PAD=1, NUM_FRAMES=2.
// Expected values are hand-computed (P=6, FRAME_LEN=72, WGT_LEN=36, ifm mem[i]=i+1, wgt mem[j]=j+1).
// Reads are driven back-to-back and outputs sampled 1 time unit after each accepting edge.
module tb_conv_stream_feeder;

    logic       clk2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       load_we = 1'b0;
    logic       load_sel = 1'b0;
    logic [5:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       ifm_read = 1'b0;
    logic       wgt_read = 1'b0;
    logic [7:0] ifm;
    logic       ifm_valid;
    logic [7:0] wgt;
    logic       wgt_valid;
    logic       frame_done;
    logic       all_done;
    logic       ovf_err;

    conv_stream_feeder #(
        .IFM_WIDTH    (8),
        .WEIGHT_WIDTH (8),
        .IFM_SIZE     (4),
        .CI           (2),
        .CO           (2),
        .KERNEL_SIZE  (3),
        .PAD          (1),
        .NUM_FRAMES   (2)
    ) dut (
        .clk2       (clk2),
        .rst_n      (rst_n),
        .start      (start),
        .load_we    (load_we),
        .load_sel   (load_sel),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .ifm_read   (ifm_read),
        .wgt_read   (wgt_read),
        .ifm        (ifm),
        .ifm_valid  (ifm_valid),
        .wgt        (wgt),
        .wgt_valid  (wgt_valid),
        .frame_done (frame_done),
        .all_done   (all_done),
        .ovf_err    (ovf_err)
    );

    always #5 clk2 = ~clk2;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] g_ifm [160];
    logic       g_iv  [160];
    logic       g_fd  [160];
    logic       g_ad  [160];
    logic       g_ov  [160];
    logic [7:0] g_w   [160];
    logic       g_wv  [160];

    typedef struct {
        int         e;
        logic [7:0] ifm;
        logic       fd;
        logic       ad;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        else n_pass++;
    endtask

    // n back-to-back ifm reads (start optionally on the first), first nw also read a weight.
    task automatic run(input int n, input bit st0, input int nw);
        @(negedge clk2);
        for (int e = 0; e < n; e++) begin
            start    = (e == 0) && st0;
            ifm_read = 1'b1;
            wgt_read = (e < nw);
            @(posedge clk2);
            #1;
            start    = 1'b0;
            ifm_read = 1'b0;
            wgt_read = 1'b0;
            g_ifm[e] = ifm;
            g_iv[e]  = ifm_valid;
            g_fd[e]  = frame_done;
            g_ad[e]  = all_done;
            g_ov[e]  = ovf_err;
            g_w[e]   = wgt;
            g_wv[e]  = wgt_valid;
        end
    endtask

    task automatic load(input logic sel, input int a, input int d);
        @(negedge clk2);
        load_we   = 1'b1;
        load_sel  = sel;
        load_addr = 6'(a);
        load_data = 8'(d);
        @(posedge clk2);
        #1;
        load_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sum0, sum1, nfd;

        tbl[0]  = '{0,   8'd0,  1'b0, 1'b0};
        tbl[1]  = '{6,   8'd0,  1'b0, 1'b0};
        tbl[2]  = '{7,   8'd1,  1'b0, 1'b0};
        tbl[3]  = '{10,  8'd4,  1'b0, 1'b0};
        tbl[4]  = '{11,  8'd0,  1'b0, 1'b0};
        tbl[5]  = '{14,  8'd6,  1'b0, 1'b0};
        tbl[6]  = '{28,  8'd16, 1'b0, 1'b0};
        tbl[7]  = '{43,  8'd17, 1'b0, 1'b0};
        tbl[8]  = '{70,  8'd0,  1'b0, 1'b0};
        tbl[9]  = '{71,  8'd0,  1'b1, 1'b0};
        tbl[10] = '{79,  8'd33, 1'b0, 1'b0};
        tbl[11] = '{100, 8'd48, 1'b0, 1'b0};
        tbl[12] = '{143, 8'd0,  1'b1, 1'b1};

        // Reset state.
        #23;
        chk("rst_ifm", 32'(ifm), 0);
        chk("rst_ifm_valid", 32'(ifm_valid), 0);
        chk("rst_wgt", 32'(wgt), 0);
        chk("rst_wgt_valid", 32'(wgt_valid), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_all_done", 32'(all_done), 0);
        chk("rst_ovf_err", 32'(ovf_err), 0);
        @(negedge clk2);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) load(1'b0, i, i + 1);
        for (int j = 0; j < 36; j++) load(1'b1, j, j + 1);

        // Two full frames with weights read alongside the first 40 ifm reads.
        run(144, 1'b1, 40);
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("ifm_e%0d", tbl[k].e), 32'(g_ifm[tbl[k].e]), 32'(tbl[k].ifm));
            chk($sformatf("ifm_valid_e%0d", tbl[k].e), 32'(g_iv[tbl[k].e]), 1);
            chk($sformatf("frame_done_e%0d", tbl[k].e), 32'(g_fd[tbl[k].e]), 32'(tbl[k].fd));
            chk($sformatf("all_done_e%0d", tbl[k].e), 32'(g_ad[tbl[k].e]), 32'(tbl[k].ad));
        end
        sum0 = 0;
        sum1 = 0;
        nfd  = 0;
        for (int e = 0; e < 144; e++) begin
            if (e < 72) sum0 += int'(g_ifm[e]);
            else        sum1 += int'(g_ifm[e]);
            if (g_fd[e] === 1'b1) nfd++;
        end
        chk("frame0_sum", 32'(sum0), 528);
        chk("frame1_sum", 32'(sum1), 1552);
        chk("frame_done_count", 32'(nfd), 2);
        for (int e = 0; e < 40; e++) begin
            chk($sformatf("wgt_r%0d", e), 32'(g_w[e]), 32'((e % 36) + 1));
            chk($sformatf("wgt_valid_r%0d", e), 32'(g_wv[e]), 1);
        end
        chk("wgt_valid_after_last", 32'(g_wv[40]), 0);
        chk("wgt_after_last", 32'(g_w[40]), 0);

        // Read after all_done: dropped and flagged.
        run(1, 1'b0, 0);
        chk("ovf_ifm_valid", 32'(g_iv[0]), 0);
        chk("ovf_ifm", 32'(g_ifm[0]), 0);
        chk("ovf_err_set", 32'(g_ov[0]), 1);
        chk("ovf_all_done_sticky", 32'(g_ad[0]), 1);

        // Start with a read mid-frame restarts at element 0.
        run(20, 1'b1, 0);
        chk("pre_restart_e19_valid", 32'(g_iv[19]), 1);
        run(8, 1'b1, 0);
        chk("restart_e0", 32'(g_ifm[0]), 0);
        chk("restart_e0_valid", 32'(g_iv[0]), 1);
        chk("restart_ovf_clear", 32'(g_ov[0]), 0);
        chk("restart_all_done_clear", 32'(g_ad[0]), 0);
        chk("restart_e1_valid", 32'(g_iv[1]), 1);
        chk("restart_e7", 32'(g_ifm[7]), 1);

        // Weight read while the same address is being written returns the old word.
        @(negedge clk2);
        start = 1'b1;
        @(negedge clk2);
        start     = 1'b0;
        wgt_read  = 1'b1;
        load_we   = 1'b1;
        load_sel  = 1'b1;
        load_addr = 6'd0;
        load_data = 8'd99;
        @(posedge clk2);
        #1;
        wgt_read = 1'b0;
        load_we  = 1'b0;
        chk("wgt_rdw_old", 32'(wgt), 1);
        chk("wgt_rdw_valid", 32'(wgt_valid), 1);
        @(negedge clk2);
        start    = 1'b1;
        wgt_read = 1'b1;
        @(posedge clk2);
        #1;
        start    = 1'b0;
        wgt_read = 1'b0;
        chk("wgt_new_after_write", 32'(wgt), 99);
        load(1'b1, 0, 1);

        // Asynchronous reset in the middle of a run.
        run(30, 1'b1, 30);
        chk("pre_reset_ifm_valid", 32'(g_iv[29]), 1);
        chk("pre_reset_wgt_valid", 32'(g_wv[29]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ifm_valid", 32'(ifm_valid), 0);
        chk("async_rst_wgt_valid", 32'(wgt_valid), 0);
        chk("async_rst_wgt", 32'(wgt), 0);
        chk("async_rst_ifm", 32'(ifm), 0);
        chk("async_rst_frame_done", 32'(frame_done), 0);
        @(negedge clk2);
        @(negedge clk2);
        rst_n = 1'b1;
        run(8, 1'b0, 0);
        chk("post_reset_e0_valid", 32'(g_iv[0]), 1);
        chk("post_reset_e7", 32'(g_ifm[7]), 1);
        chk("post_reset_ovf", 32'(g_ov[7]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
